// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Front end of the pipeline. It holds the PC, a word-addressed instruction
// memory read combinationally, and a small prefetch FIFO that hands
// {instruction, pc} pairs to decode over a valid/ready handshake.
// Optional build macro: IF_BOUNDS_CHECK_EN.
//   - Defined: fetches past the end of memory stall and raise a sticky fetch_fault.
//   - Undefined: the word index wraps and fetch_fault is held at 0.
module instruction_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 256,
    parameter int                    FIFO_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  redirect_en,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  instr_ready,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instruction_output,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  fetch_fault
);

    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    // Read-only program store; contents are loaded hierarchically by the environment.
    logic [DATA_WIDTH-1:0] instruction_memory [0:MEM_DEPTH-1];

    // Prefetch queue storage and control state.
    logic [DATA_WIDTH-1:0] r_fifo_data [0:FIFO_DEPTH-1];
    logic [ADDR_WIDTH-1:0] r_fifo_pc   [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [ADDR_WIDTH-1:0] r_pc;

    // Registered copies of the head entry presented to decode.
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [ADDR_WIDTH-1:0] r_out_pc;
    logic                  r_fault;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_fault_stall;
    logic [ADDR_WIDTH-1:0] w_redirect_aligned;
    logic [MEM_AW-1:0]     w_mem_idx;
    logic [DATA_WIDTH-1:0] w_fetch_data;
    logic [PTR_W-1:0]      w_rd_nxt;
    logic [PTR_W-1:0]      w_wr_nxt;
    logic [CNT_W-1:0]      w_count_nxt;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [ADDR_WIDTH-1:0] w_head_pc;

    // True when a byte address points beyond the last memory word.
    function automatic logic addr_out_of_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr[ADDR_WIDTH-1:MEM_AW+2] != '0);
    endfunction

    assign w_redirect_aligned = redirect_pc & ALIGN_MASK;
    assign w_mem_idx          = r_pc[MEM_AW+1:2];
    assign w_fetch_data       = instruction_memory[w_mem_idx];

`ifdef IF_BOUNDS_CHECK_EN
    assign w_fault_stall = addr_out_of_range(r_pc);
`else
    assign w_fault_stall = 1'b0;
`endif

    // Handshake decode plus next pointer/count values for the prefetch queue.
    always_comb begin
        w_pop       = r_valid & instr_ready;
        w_push      = ((r_count < FULL_CNT) | w_pop) & ~redirect_en & ~w_fault_stall;
        w_rd_nxt    = r_rd_ptr;
        w_wr_nxt    = r_wr_ptr;
        w_count_nxt = r_count;
        if (redirect_en) begin
            // A redirect discards everything, including a pop offered this cycle.
            w_rd_nxt    = '0;
            w_wr_nxt    = '0;
            w_count_nxt = '0;
        end else begin
            if (w_pop) begin
                w_rd_nxt = r_rd_ptr + PTR_ONE;
            end else begin
                w_rd_nxt = r_rd_ptr;
            end
            if (w_push) begin
                w_wr_nxt = r_wr_ptr + PTR_ONE;
            end else begin
                w_wr_nxt = r_wr_ptr;
            end
            if (w_push && !w_pop) begin
                w_count_nxt = r_count + CNT_ONE;
            end else if (!w_push && w_pop) begin
                w_count_nxt = r_count - CNT_ONE;
            end else begin
                w_count_nxt = r_count;
            end
        end
    end

    // Select what the head of the queue will be after this edge.
    always_comb begin
        w_head_data = r_out_data;
        w_head_pc   = r_out_pc;
        if (w_count_nxt == '0) begin
            // Empty: keep the last presented values; they are don't-care downstream.
            w_head_data = r_out_data;
            w_head_pc   = r_out_pc;
        end else if (w_push && (r_wr_ptr == w_rd_nxt)) begin
            // The entry being written is also the new head (queue had nothing else).
            w_head_data = w_fetch_data;
            w_head_pc   = r_pc;
        end else begin
            w_head_data = r_fifo_data[w_rd_nxt];
            w_head_pc   = r_fifo_pc[w_rd_nxt];
        end
    end

    // Queue storage: write the fetched word and its address at the write pointer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_fetch_data;
            r_fifo_pc[r_wr_ptr]   <= r_pc;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_rd_nxt;
            r_wr_ptr <= w_wr_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Program counter: jump on redirect, advance one word on every push, else hold.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pc <= RESET_PC;
        end else if (redirect_en) begin
            r_pc <= w_redirect_aligned;
        end else if (w_push) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    // Registered head-of-queue outputs so decode never sees a path from instr_ready.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_valid    <= 1'b0;
            r_out_data <= '0;
            r_out_pc   <= '0;
        end else begin
            r_valid    <= (w_count_nxt != '0);
            r_out_data <= w_head_data;
            r_out_pc   <= w_head_pc;
        end
    end

`ifdef IF_BOUNDS_CHECK_EN
    // Sticky bounds fault: set on an out-of-range fetch, cleared by an in-range redirect.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_fault <= 1'b0;
        end else if (redirect_en) begin
            r_fault <= addr_out_of_range(w_redirect_aligned) ? r_fault : 1'b0;
        end else if (w_fault_stall) begin
            r_fault <= 1'b1;
        end
    end
`else
    // Bounds checking is compiled out; the fault flag stays low.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_fault_stall;
        end
    end
`endif

    assign instr_valid        = r_valid;
    assign instruction_output = r_out_data;
    assign instr_pc           = r_out_pc;
    assign fetch_fault        = r_fault;

endmodule
